// File: rtl/multicycle_control_unit.sv
// =============================================================================
// Module      : multicycle_control_unit
// Description : Multi-cycle CPU control unit. Handles instruction fetch,
//               decode, execute, RAM access and write-back sequencing.
//               Define CU_RETIRE_CNT_EN to build the retired-instruction counter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module multicycle_control_unit #(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4,
    parameter int REG_AW  = 2,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               instr_req,
    output logic [ADDR_W-1:0]  instr_addr,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic               zero_flag,
    output logic [OPC_W-1:0]   alu_code,
    output logic               alu_en,
    output logic [REG_AW-1:0]  reg1,
    output logic [REG_AW-1:0]  reg2,
    output logic               reg_read,
    output logic               reg_write,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [OPC_W-1:0] c_OP_ALU_MAX = OPC_W'(7);
    localparam logic [OPC_W-1:0] c_OP_JMP     = OPC_W'(8);
    localparam logic [OPC_W-1:0] c_OP_JZ      = OPC_W'(9);
    localparam logic [OPC_W-1:0] c_OP_LOAD    = OPC_W'(10);
    localparam logic [OPC_W-1:0] c_OP_STORE   = OPC_W'(11);
    localparam logic [OPC_W-1:0] c_OP_NOP     = OPC_W'(12);
    localparam logic [OPC_W-1:0] c_OP_ILL0    = OPC_W'(13);
    localparam logic [OPC_W-1:0] c_OP_ILL1    = OPC_W'(14);
    localparam logic [OPC_W-1:0] c_OP_HALT    = OPC_W'(15);

    state_t              r_state;
    state_t              w_next_state;
    logic [INSTR_W-1:0]  r_ir;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;

    logic [OPC_W-1:0]    w_opc;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_is_alu;
    logic                w_is_store;

    // Instruction fields are driven straight from the IR at all times
    assign w_opc      = r_ir[INSTR_W-1 -: OPC_W];
    assign w_addr     = r_ir[ADDR_W-1:0];
    assign w_is_alu   = (w_opc <= c_OP_ALU_MAX);
    assign w_is_store = (w_opc == c_OP_STORE);

    assign alu_code   = w_opc;
    assign reg1       = r_ir[INSTR_W-OPC_W-1 -: REG_AW];
    assign reg2       = r_ir[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
    assign mem_addr   = w_addr;
    assign pc         = r_pc;
    assign instr_addr = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_pc    <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            if (r_state == S_FETCH && instr_valid) begin
                r_ir <= instr_data;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        instr_req    = 1'b0;
        alu_en       = 1'b0;
        reg_read     = 1'b0;
        reg_write    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        halted       = 1'b0;
        illegal      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    w_next_state = S_DECODE;
                    w_pc_next    = r_pc + ADDR_W'(1);
                end
            end
            S_DECODE: begin
                if (w_opc == c_OP_HALT) begin
                    w_next_state = S_HALT;
                end else if (w_opc == c_OP_ILL0 || w_opc == c_OP_ILL1) begin
                    illegal      = 1'b1;
                    w_next_state = S_FETCH;
                end else if (w_opc == c_OP_NOP) begin
                    w_next_state = S_FETCH;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_is_alu) begin
                    alu_en       = 1'b1;
                    reg_read     = 1'b1;
                    w_next_state = S_WB;
                end else if (w_opc == c_OP_JMP) begin
                    w_pc_next    = w_addr;
                    w_next_state = S_FETCH;
                end else if (w_opc == c_OP_JZ) begin
                    if (zero_flag) begin
                        w_pc_next = w_addr;
                    end
                    w_next_state = S_FETCH;
                end else if (w_opc == c_OP_LOAD) begin
                    w_next_state = S_MEM;
                end else if (w_is_store) begin
                    reg_read     = 1'b1;
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = w_is_store;
                reg_read = w_is_store;
                if (mem_ready) begin
                    w_next_state = w_is_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

`ifdef CU_RETIRE_CNT_EN
    logic             w_retire;
    logic [CNT_W-1:0] r_retire_cnt;

    // An instruction retires whenever a working state hands back to FETCH or HALT
    assign w_retire = (r_state == S_DECODE || r_state == S_EXEC ||
                       r_state == S_MEM    || r_state == S_WB) &&
                      (w_next_state == S_FETCH || w_next_state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign retire_cnt = r_retire_cnt;
`else
    assign retire_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// =============================================================================
// Module      : tb_multicycle_control_unit
// Description : Self-checking bench for multicycle_control_unit with a
//               per-instruction behavioural reference model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_multicycle_control_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic        zero_flag;
    logic [3:0]  alu_code;
    logic        alu_en;
    logic [1:0]  reg1;
    logic [1:0]  reg2;
    logic        reg_read;
    logic        reg_write;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic        mem_ready;
    logic [7:0]  pc;
    logic        halted;
    logic        illegal;
    logic [15:0] retire_cnt;

    int          n_vec;
    int          n_err;
    logic [7:0]  m_pc;
    logic [15:0] m_cnt;

    // Summary of one instruction's externally visible behaviour
    typedef struct packed {
        logic       timeout;
        logic       halt_seen;
        logic [7:0] fetch_addr;
        logic [7:0] lat;
        logic [7:0] next_addr;
        logic [3:0] alu_en_n;
        logic [3:0] reg_write_n;
        logic [3:0] illegal_n;
        logic [7:0] reg_read_n;
        logic [7:0] mem_req_n;
        logic [7:0] mem_we_n;
        logic [3:0] alu_op;
        logic [1:0] wr_reg;
        logic [7:0] maddr;
    } obs_t;

    multicycle_control_unit #(
        .INSTR_W (16),
        .OPC_W   (4),
        .REG_AW  (2),
        .ADDR_W  (8),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .zero_flag   (zero_flag),
        .alu_code    (alu_code),
        .alu_en      (alu_en),
        .reg1        (reg1),
        .reg2        (reg2),
        .reg_read    (reg_read),
        .reg_write   (reg_write),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .pc          (pc),
        .halted      (halted),
        .illegal     (illegal),
        .retire_cnt  (retire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] exp_cnt();
`ifdef CU_RETIRE_CNT_EN
        return m_cnt;
`else
        return 16'h0000;
`endif
    endfunction

    // Expected outcome of one instruction fetched at address a, with d stall cycles
    function automatic obs_t model(input logic [15:0] ins, input logic [7:0] a,
                                   input bit zf, input int d);
        obs_t       e;
        int         opc;
        logic [7:0] tgt;
        e            = '0;
        opc          = int'(ins[15:12]);
        tgt          = ins[7:0];
        e.fetch_addr = a;
        e.next_addr  = a + 8'd1;
        if (opc < 8) begin
            e.lat = 8'd4; e.alu_en_n = 4'd1; e.reg_write_n = 4'd1; e.reg_read_n = 8'd1;
            e.alu_op = ins[15:12]; e.wr_reg = ins[11:10];
        end else if (opc == 8) begin
            e.lat = 8'd3; e.next_addr = tgt;
        end else if (opc == 9) begin
            e.lat = 8'd3;
            if (zf) e.next_addr = tgt;
        end else if (opc == 10) begin
            e.lat = 8'(5 + d); e.mem_req_n = 8'(d + 1); e.reg_write_n = 4'd1;
            e.wr_reg = ins[11:10]; e.maddr = tgt;
        end else if (opc == 11) begin
            e.lat = 8'(4 + d); e.mem_req_n = 8'(d + 1); e.mem_we_n = 8'(d + 1);
            e.reg_read_n = 8'(d + 2); e.maddr = tgt;
        end else if (opc == 12) begin
            e.lat = 8'd2;
        end else if (opc == 15) begin
            e.halt_seen = 1'b1; e.next_addr = 8'd0;
        end else begin
            e.lat = 8'd2; e.illegal_n = 4'd1;
        end
        return e;
    endfunction

    task automatic do_reset();
        rst_n       = 1'b1;
        #1;
        rst_n       = 1'b0;
        start       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = '0;
        zero_flag   = 1'b0;
        mem_ready   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_pc  = 8'd0;
        m_cnt = 16'd0;
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds one instruction and records what the DUT does until it fetches again or halts
    task automatic run_instr(input logic [15:0] ins, input int d, input bit zf,
                             output obs_t o);
        int cyc;
        int mcyc;
        o = '0;
        @(negedge clk);
        o.fetch_addr = instr_addr;
        instr_valid  = 1'b1;
        instr_data   = ins;
        zero_flag    = zf;
        cyc  = 1;
        mcyc = 0;
        while (1) begin
            @(negedge clk);
            if (alu_en)    begin o.alu_en_n++;    o.alu_op = alu_code; end
            if (reg_write) begin o.reg_write_n++; o.wr_reg = reg1;     end
            if (mem_req)   begin o.mem_req_n++;   o.maddr  = mem_addr; end
            if (mem_we)    o.mem_we_n++;
            if (reg_read)  o.reg_read_n++;
            if (illegal)   o.illegal_n++;
            if (halted) begin
                o.halt_seen = 1'b1;
                break;
            end
            if (instr_req) begin
                o.lat       = 8'(cyc);
                o.next_addr = instr_addr;
                break;
            end
            cyc++;
            if (cyc > 60) begin
                o.timeout = 1'b1;
                break;
            end
            instr_valid = 1'($urandom);
            instr_data  = 16'($urandom);
            start       = 1'($urandom);
            if (mem_req) begin
                mcyc++;
                mem_ready = (mcyc > d);
            end else begin
                mem_ready = 1'($urandom);
            end
        end
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        start       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        start = 1'b0; instr_valid = 1'b0; instr_data = '0; zero_flag = 1'b0; mem_ready = 1'b0;
        #1;
        n_vec++;
        if ({instr_req, alu_en, reg_read, reg_write, mem_req, mem_we, halted, illegal} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_strobes: got %b expected 00000000",
                     {instr_req, alu_en, reg_read, reg_write, mem_req, mem_we, halted, illegal});
        end
        n_vec++;
        if ({pc, alu_code, mem_addr, reg1, reg2, retire_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_regs: got pc=%h op=%h ma=%h r1=%h r2=%h cnt=%h expected all 0",
                     pc, alu_code, mem_addr, reg1, reg2, retire_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_pc = 8'd0; m_cnt = 16'd0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (instr_req !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold: got instr_req=%b expected 0", instr_req);
        end
        kick();
        n_vec++;
        if (instr_req !== 1'b1 || instr_addr !== 8'h00) begin
            n_err++;
            $display("FAIL start_fetch: got req=%b addr=%h expected req=1 addr=00", instr_req, instr_addr);
        end
    endtask

    task automatic test_directed();
        logic [15:0] t_ins [0:13] = '{16'h4800, 16'h8004, 16'h9010, 16'hA812, 16'hD800,
                                      16'hC000, 16'hB834, 16'h8000, 16'h9033, 16'h80FF,
                                      16'h1700, 16'h80FF, 16'h90AB, 16'hE100};
        int          t_d   [0:13] = '{0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        bit          t_z   [0:13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        obs_t o;
        obs_t e;
        do_reset();
        kick();
        for (int i = 0; i < 14; i++) begin
            e = model(t_ins[i], m_pc, t_z[i], t_d[i]);
            run_instr(t_ins[i], t_d[i], t_z[i], o);
            m_pc = e.next_addr;
            m_cnt++;
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL directed_%0d instr=%h: got %h expected %h", i, t_ins[i], o, e);
            end
        end
        n_vec++;
        if (retire_cnt !== exp_cnt()) begin
            n_err++;
            $display("FAIL directed_retire: got %0d expected %0d", retire_cnt, exp_cnt());
        end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        int          d;
        bit          zf;
        obs_t        o;
        obs_t        e;
        do_reset();
        kick();
        for (int i = 0; i < 60; i++) begin
            ins = {4'($urandom_range(0, 14)), 12'($urandom)};
            d   = int'($urandom_range(0, 3));
            zf  = 1'($urandom);
            e   = model(ins, m_pc, zf, d);
            run_instr(ins, d, zf, o);
            m_pc = e.next_addr;
            m_cnt++;
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL random_%0d instr=%h d=%0d zf=%0d: got %h expected %h",
                         i, ins, d, zf, o, e);
            end
            n_vec++;
            if (retire_cnt !== exp_cnt()) begin
                n_err++;
                $display("FAIL random_retire_%0d: got %0d expected %0d", i, retire_cnt, exp_cnt());
            end
        end
    endtask

    task automatic test_halt();
        obs_t o;
        obs_t e;
        logic [15:0] seq [0:2] = '{16'h4800, 16'hC000, 16'hF000};
        do_reset();
        kick();
        for (int i = 0; i < 3; i++) begin
            e = model(seq[i], m_pc, 1'b0, 0);
            run_instr(seq[i], 0, 1'b0, o);
            m_pc = e.next_addr;
            m_cnt++;
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL halt_seq_%0d: got %h expected %h", i, o, e);
            end
        end
        start = 1'b1;
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (halted !== 1'b1 || instr_req !== 1'b0 || retire_cnt !== exp_cnt()) begin
                n_err++;
                $display("FAIL halt_hold_%0d: got halted=%b req=%b cnt=%0d expected 1 0 %0d",
                         i, halted, instr_req, retire_cnt, exp_cnt());
            end
        end
        start = 1'b0;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        int w;
        do_reset();
        kick();
        @(negedge clk);
        instr_valid = 1'b1;
        instr_data  = 16'hA812;
        mem_ready   = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            instr_valid = 1'b0;
            w++;
        end while (!mem_req && w < 10);
        n_vec++;
        if (mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL mid_mem_reach: got mem_req=%b expected 1 within 10 cycles", mem_req);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({mem_req, instr_req, reg_write, reg_read, mem_we, halted} !== 6'b0 ||
            pc !== 8'h00 || retire_cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_mem_reset: got mreq=%b req=%b pc=%h cnt=%0d expected 0 0 00 0",
                     mem_req, instr_req, pc, retire_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 8'd0; m_cnt = 16'd0;
        @(negedge clk);
        n_vec++;
        if (instr_req !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL mid_mem_idle: got req=%b mreq=%b expected 0 0", instr_req, mem_req);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        start = 1'b0; instr_valid = 1'b0; instr_data = '0; zero_flag = 1'b0; mem_ready = 1'b0;
        m_pc = 8'd0; m_cnt = 16'd0;
        #2;
        test_reset();
        test_directed();
        test_random();
        test_halt();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
